// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: fetch FSM states and fixed constants.
package mips_pkg;
  typedef enum logic [1:0] {FETCH, DISCARD, DRAIN} fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction word that returns while ID is stalled.
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (clear || unload) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem handshake, IF/ID register.
// Define DELAY_SLOT_EN for delay-slot redirects; default build squashes on redirect.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        skid_load, skid_unload, skid_clear, skid_valid;
  logic [31:0] skid_instr, skid_pc_plus4;
  logic        redirect;
  logic [31:0] target, pc_plus4;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (skid_clear),
    .instr_in   (imem_rdata),
    .pc_plus4_in(pc_plus4),
    .instr      (skid_instr),
    .pc_plus4   (skid_pc_plus4),
    .valid      (skid_valid)
  );

  // A full skid means the word for pc was already returned, so no request is outstanding.
  assign imem_req  = ~reset & ~skid_valid;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + PC_STEP;
  assign target    = jump ? jump_target : branch_target;
  assign redirect  = (branch | jump) & if_id_valid_q & ~stall & (state_q == FETCH);

`ifdef DELAY_SLOT_EN
  logic deliver;
  assign deliver = ~stall & (skid_valid | imem_ready);
`endif

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    redirect_pc_d    = redirect_pc_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_valid_d    = if_id_valid_q;
    skid_load        = 1'b0;
    skid_unload      = 1'b0;
    skid_clear       = 1'b0;

    if (state_q == DISCARD) begin
      if_id_valid_d = 1'b0;
      if (imem_ready) begin
        pc_d    = redirect_pc_q;
        state_d = FETCH;
      end
    end else begin
      if (stall) begin
        if (imem_ready) begin
          skid_load = 1'b1;
          pc_d      = pc_plus4;
        end
      end else if (skid_valid) begin
        if_id_instr_d    = skid_instr;
        if_id_pc_plus4_d = skid_pc_plus4;
        if_id_valid_d    = 1'b1;
        skid_unload      = 1'b1;
      end else if (imem_ready) begin
        if_id_instr_d    = imem_rdata;
        if_id_pc_plus4_d = pc_plus4;
        if_id_valid_d    = 1'b1;
        pc_d             = pc_plus4;
      end else begin
        if_id_valid_d = 1'b0;
      end

`ifdef DELAY_SLOT_EN
      // The next delivered word is the delay slot; redirect once it lands in IF/ID.
      if (redirect) begin
        if (deliver) begin
          pc_d = target;
        end else begin
          redirect_pc_d = target;
          state_d       = DRAIN;
        end
      end else if (state_q == DRAIN && deliver) begin
        pc_d    = redirect_pc_q;
        state_d = FETCH;
      end
`else
      if (redirect) begin
        if_id_valid_d = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b1;
        if (imem_ready || !imem_req) begin
          pc_d = target;
        end else begin
          redirect_pc_d = target;
          state_d       = DISCARD;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= FETCH;
      pc_q             <= RESET_PC;
      redirect_pc_q    <= RESET_PC;
      if_id_instr_q    <= NOP_INSTR;
      if_id_pc_plus4_q <= 32'h0;
      if_id_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      redirect_pc_q    <= redirect_pc_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_valid    = if_id_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based transaction model of the fetch rules.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, imem_ready;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc_plus4;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: fetch pointer, pending target, skid as a queue.
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  ent_t        m_skid[$];
  logic [31:0] m_pc, m_tgt, m_ifi, m_ifp;
  bit          m_ifv, m_disc, m_drain, cur_rst;

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFF8;
      1:       return $urandom_range(255);
      default: return 32'($urandom_range(63)) << 2;
    endcase
  endfunction

  task automatic drive(input int mode);
    reset  = (mode == 0) || (mode == 2 && $urandom_range(63) == 0);
    stall  = (mode == 2) && ($urandom_range(3) == 0);
    branch = (mode == 2) && ($urandom_range(4) == 0);
    jump   = (mode == 2) && ($urandom_range(7) == 0);
    branch_target = pick_target();
    jump_target   = pick_target();
    imem_ready = !reset && m_skid.size() == 0 && (mode == 1 || $urandom_range(1) == 1);
    imem_rdata = imem_ready ? mem_word(m_pc) : 32'hDEAD_BEEF;
    cur_rst    = reset;
  endtask

  task automatic model_step();
    bit redir, dlv, req;
    logic [31:0] t;
    ent_t e;
    if (reset) begin
      m_pc = 0; m_skid.delete(); m_disc = 0; m_drain = 0;
      m_ifv = 0; m_ifi = 0; m_ifp = 0;
      return;
    end
    req = m_skid.size() == 0;
    if (m_disc) begin
      m_ifv = 0;
      if (imem_ready) begin m_pc = m_tgt; m_disc = 0; end
      return;
    end
    redir = (branch || jump) && m_ifv && !stall && !m_drain;
    t = jump ? jump_target : branch_target;
`ifndef DELAY_SLOT_EN
    if (redir) begin
      m_ifv = 0;
      m_skid.delete();
      if (imem_ready || !req) m_pc = t;
      else begin m_tgt = t; m_disc = 1; end
      return;
    end
`endif
    dlv = 0;
    if (stall) begin
      if (imem_ready) begin
        e.instr = imem_rdata; e.pc4 = m_pc + 4;
        m_skid.push_back(e);
        m_pc = m_pc + 4;
      end
    end else if (m_skid.size() != 0) begin
      e = m_skid.pop_front();
      m_ifi = e.instr; m_ifp = e.pc4; m_ifv = 1; dlv = 1;
    end else if (imem_ready) begin
      m_ifi = imem_rdata; m_ifp = m_pc + 4; m_ifv = 1; dlv = 1;
      m_pc = m_pc + 4;
    end else begin
      m_ifv = 0;
    end
`ifdef DELAY_SLOT_EN
    if (redir) begin
      if (dlv) m_pc = t;
      else begin m_tgt = t; m_drain = 1; end
    end else if (m_drain && dlv) begin
      m_pc = m_tgt; m_drain = 0;
    end
`endif
  endtask

  task automatic cycle(input int mode, input int zw_k);
    @(negedge clk);
    check("req",  {31'b0, imem_req}, {31'b0, !cur_rst && m_skid.size() == 0});
    check("addr", imem_addr, m_pc);
    check("vld",  {31'b0, if_id_valid}, {31'b0, m_ifv});
    if (m_ifv || cur_rst) begin
      check("pc4",   if_id_pc_plus4, m_ifp);
      check("instr", if_id_instr, m_ifi);
    end
    if (m_ifv) check("data", if_id_instr, mem_word(m_ifp - 32'd4));
    if (zw_k >= 0) begin
      check("zw_addr", imem_addr, 32'(zw_k) * 4);
      if (zw_k >= 1) check("zw_pc4", if_id_pc_plus4, 32'(zw_k) * 4);
    end
    drive(mode);
    @(posedge clk);
    model_step();
  endtask

  initial begin
    cur_rst = 1'b1;
    m_pc = 0; m_ifv = 0; m_ifi = 0; m_ifp = 0; m_disc = 0; m_drain = 0; m_tgt = 0;
    drive(0);
    @(posedge clk);
    model_step();
    for (int i = 0; i < 2; i++) cycle(0, -1);
    for (int k = 0; k < 6; k++) cycle(1, k);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 2; i++) cycle(0, -1);
      for (int i = 0; i < 800; i++) cycle(2, -1);
    end
    cycle(1, -1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
